// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr}; entry 0 is always the head, so the
// head output comes straight from a register. Flush wins over push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    fetch_entry_t r_e0;
    fetch_entry_t r_e1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    always_comb begin
        w_pop  = i_pop && (r_count != 2'd0);
        w_push = i_push && ((r_count != FULL) || w_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_e0    <= i_entry;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_e0 <= i_entry;
                    end else if (w_push) begin
                        r_e1    <= i_entry;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a pop shifts entry 1 forward; a simultaneous push refills it.
                    if (w_pop) begin
                        r_e0 <= r_e1;
                        if (w_push) begin
                            r_e1 <= i_entry;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head  = r_e0;
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, buffers words for decode.
// Optional perf counters (perf_fetch_cnt / perf_stall_cnt) under `FETCH_PERF_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                halt_req,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic [PC_W-1:0]     out_pc_plus4,
    output logic                halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_redirect_pc;
    logic [1:0]      w_count;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;

    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_full        = (w_count == 2'(FIFO_DEPTH));
    assign out_valid     = (w_count != 2'd0);
    assign w_pop         = out_valid && out_ready;
    assign w_push        = (r_state == S_RUN) && !redirect_valid && !halt_req
                           && (!w_full || w_pop);
    assign w_entry       = '{pc: r_pc, instr: imem_data};

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_RUN;
                S_RUN:   if (halt_req) w_state_nxt = S_HALT;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr    = r_pc;
    assign out_instr    = w_head.instr;
    assign out_pc       = w_head.pc;
    assign out_pc_plus4 = w_head.pc + PC_STEP;
    assign halted       = (r_state == S_HALT);

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((r_state == S_RUN) && !w_push && !redirect_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirect, halt,
// PC wrap (second instance) and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;

    logic [31:0] b_imem_addr;
    logic [31:0] b_imem_data;
    logic        b_out_valid;
    logic [31:0] b_out_instr;
    logic [31:0] b_out_pc;
    logic [31:0] b_out_pc_plus4;
    logic        b_halted;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] b_perf_fetch_cnt;
    logic [31:0] b_perf_stall_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Memory image: word i holds 32'h1000_0000 + i.
    assign imem_data   = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
    assign b_imem_data = 32'h1000_0000 + {2'b00, b_imem_addr[31:2]};

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (b_imem_addr),
        .imem_data      (b_imem_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .halt_req       (1'b0),
        .out_valid      (b_out_valid),
        .out_ready      (1'b1),
        .out_instr      (b_out_instr),
        .out_pc         (b_out_pc),
        .out_pc_plus4   (b_out_pc_plus4),
        .halted         (b_halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (b_perf_fetch_cnt),
        .perf_stall_cnt (b_perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b_pc_tab    [3];
        logic [31:0] b_instr_tab [3];
        logic [31:0] b_p4_tab    [3];
        b_pc_tab    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        b_instr_tab = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
        b_p4_tab    = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid",   {31'b0, out_valid}, 32'd0);
        check("rst_instr",   out_instr,          32'h0);
        check("rst_pc",      out_pc,             32'h0);
        check("rst_pc4",     out_pc_plus4,       32'h4);
        check("rst_halted",  {31'b0, halted},    32'd0);
        check("rst_addr",    imem_addr,          32'h0);
        check("rst_b_addr",  b_imem_addr,        32'hFFFF_FFF8);
        check("rst_b_pc4",   b_out_pc_plus4,     32'h4);

        rst_n = 1'b1;
        step();
        check("boot_valid",   {31'b0, out_valid},   32'd0);
        check("boot_addr",    imem_addr,            32'h0);
        check("boot_b_valid", {31'b0, b_out_valid}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            step();
            check("strm_valid", {31'b0, out_valid}, 32'd1);
            check("strm_pc",    out_pc,             32'(4 * k));
            check("strm_instr", out_instr,          32'h1000_0000 + 32'(k));
            check("strm_pc4",   out_pc_plus4,       32'(4 * k + 4));
            check("wrap_valid", {31'b0, b_out_valid}, 32'd1);
            check("wrap_pc",    b_out_pc,           b_pc_tab[k]);
            check("wrap_instr", b_out_instr,        b_instr_tab[k]);
            check("wrap_pc4",   b_out_pc_plus4,     b_p4_tab[k]);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch_a", perf_fetch_cnt, 32'd3);
        check("perf_stall_a", perf_stall_cnt, 32'd0);
`endif

        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_pc",    out_pc,             32'h8);
            check("stall_instr", out_instr,          32'h1000_0002);
            check("stall_addr",  imem_addr,          32'h10);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch_b", perf_fetch_cnt, 32'd4);
        check("perf_stall_b", perf_stall_cnt, 32'd4);
`endif

        out_ready = 1'b1;
        for (int k = 3; k < 6; k++) begin
            step();
            check("rel_pc",    out_pc,    32'(4 * k));
            check("rel_instr", out_instr, 32'h1000_0000 + 32'(k));
        end

        out_ready = 1'b0;
        step();
        check("full_pc",   out_pc,    32'h14);
        check("full_addr", imem_addr, 32'h1C);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        check("redir_addr",  imem_addr,          32'h40);
        step();
        check("redir_hvalid", {31'b0, out_valid}, 32'd1);
        check("redir_pc",     out_pc,             32'h40);
        check("redir_instr",  out_instr,          32'h1000_0010);
        check("redir_pc4",    out_pc_plus4,       32'h44);
        step();
        check("redir_next",   out_pc,             32'h44);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_001A;
        step();
        redirect_valid = 1'b0;
        check("r2_addr",  imem_addr,          32'h18);
        check("r2_valid", {31'b0, out_valid}, 32'd0);
        step();
        step();
        check("r2_pc",    out_pc,    32'h1C);
        check("r2_addr2", imem_addr, 32'h20);

        halt_req  = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step();
            check("halt_flag",  {31'b0, halted},    32'd1);
            check("halt_addr",  imem_addr,          32'h20);
            check("halt_valid", {31'b0, out_valid}, 32'd1);
            check("halt_pc",    out_pc,             32'h1C);
        end
        halt_req  = 1'b0;
        out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            check("drain_valid", {31'b0, out_valid}, 32'd0);
            check("drain_flag",  {31'b0, halted},    32'd1);
            check("drain_addr",  imem_addr,          32'h20);
        end

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("resume_flag",  {31'b0, halted},    32'd0);
        check("resume_addr",  imem_addr,          32'h100);
        check("resume_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("resume_pc",    out_pc,             32'h100);
        check("resume_instr", out_instr,          32'h1000_0040);
        check("resume_hv",    {31'b0, out_valid}, 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  {31'b0, out_valid}, 32'd0);
        check("arst_addr",   imem_addr,          32'h0);
        check("arst_pc4",    out_pc_plus4,       32'h4);
        check("arst_halted", {31'b0, halted},    32'd0);
        check("arst_b_addr", b_imem_addr,        32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        check("arst_fetch",  perf_fetch_cnt,     32'd0);
        check("arst_stall",  perf_stall_cnt,     32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
